// File: rtl/qdrc_pkg.sv
// rtl/qdrc_pkg.sv - shared register map, STATUS bit indices and FSM encoding for the QDR CPU bridge
package qdrc_pkg;

    localparam logic [3:0] REG_WDATA0 = 4'd0;
    localparam logic [3:0] REG_WDATA1 = 4'd1;
    localparam logic [3:0] REG_WDATA2 = 4'd2;
    localparam logic [3:0] REG_BE     = 4'd3;
    localparam logic [3:0] REG_ADDR   = 4'd4;
    localparam logic [3:0] REG_CTRL   = 4'd5;
    localparam logic [3:0] REG_STATUS = 4'd6;
    localparam logic [3:0] REG_RDATA0 = 4'd8;
    localparam logic [3:0] REG_RDATA1 = 4'd9;
    localparam logic [3:0] REG_RDATA2 = 4'd10;

    localparam int ST_BUSY    = 0;
    localparam int ST_TIMEOUT = 1;
    localparam int ST_PHY_RDY = 2;
    localparam int ST_REJECT  = 3;

    localparam int CTRL_WR = 0;
    localparam int CTRL_RD = 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITE     = 2'd1,
        S_READ_REQ  = 2'd2,
        S_READ_WAIT = 2'd3
    } qdrc_state_e;

endpackage

// File: rtl/qdrc_cpu_bridge_if.sv
// rtl/qdrc_cpu_bridge_if.sv - QDR controller user port; master is the bridge, slave is the controller
interface qdrc_cpu_bridge_if #(
    parameter int DATA_WIDTH = 36,
    parameter int BW_WIDTH   = 4,
    parameter int ADDR_WIDTH = 21
);
    logic                    phy_rdy;
    logic                    usr_rd_strb;
    logic                    usr_wr_strb;
    logic [ADDR_WIDTH-1:0]   usr_addr;
    logic [2*DATA_WIDTH-1:0] usr_wr_data;
    logic [2*BW_WIDTH-1:0]   usr_wr_be;
    logic [2*DATA_WIDTH-1:0] usr_rd_data;
    logic                    usr_rd_dvld;

    modport master (
        input  phy_rdy, usr_rd_data, usr_rd_dvld,
        output usr_rd_strb, usr_wr_strb, usr_addr, usr_wr_data, usr_wr_be
    );

    modport slave (
        output phy_rdy, usr_rd_data, usr_rd_dvld,
        input  usr_rd_strb, usr_wr_strb, usr_addr, usr_wr_data, usr_wr_be
    );
endinterface

// File: rtl/qdrc_cpu_regfile.sv
// rtl/qdrc_cpu_regfile.sv - CPU register decode, staging/RDATA registers and registered read port
module qdrc_cpu_regfile
    import qdrc_pkg::*;
#(
    parameter int DATA_WIDTH = 36,
    parameter int BW_WIDTH   = 4,
    parameter int ADDR_WIDTH = 21
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              cpu_addr,
    input  logic                    cpu_wr_strb,
    input  logic                    cpu_rd_strb,
    input  logic [31:0]             cpu_din,
    output logic [31:0]             cpu_dout,
    output logic                    cpu_ack,
    input  logic                    busy,
    input  logic                    timeout,
    input  logic                    reject,
    input  logic                    phy_rdy,
    input  logic                    rd_capture,
    input  logic [2*DATA_WIDTH-1:0] rd_data,
    output logic [2*DATA_WIDTH-1:0] stage_wdata,
    output logic [2*BW_WIDTH-1:0]   stage_be,
    output logic [ADDR_WIDTH-1:0]   stage_addr,
    output logic                    start_wr,
    output logic                    start_rd
);
    localparam int BURST_W = 2 * DATA_WIDTH;

    logic [BURST_W-1:0] rdata_q;
    logic [95:0]        wdata_ext;
    logic [95:0]        rdata_ext;
    logic [31:0]        rd_mux;

    // Burst registers are zero-extended to three full words so unused upper bits read back 0.
    always_comb begin
        wdata_ext = '0;
        rdata_ext = '0;
        wdata_ext[BURST_W-1:0] = stage_wdata;
        rdata_ext[BURST_W-1:0] = rdata_q;
    end

    always_comb begin
        rd_mux = '0;
        case (cpu_addr)
            REG_WDATA0: rd_mux = wdata_ext[31:0];
            REG_WDATA1: rd_mux = wdata_ext[63:32];
            REG_WDATA2: rd_mux = wdata_ext[95:64];
            REG_BE:     rd_mux[2*BW_WIDTH-1:0] = stage_be;
            REG_ADDR:   rd_mux[ADDR_WIDTH-1:0] = stage_addr;
            REG_STATUS: begin
                rd_mux[ST_BUSY]    = busy;
                rd_mux[ST_TIMEOUT] = timeout;
                rd_mux[ST_PHY_RDY] = phy_rdy;
                rd_mux[ST_REJECT]  = reject;
            end
            REG_RDATA0: rd_mux = rdata_ext[31:0];
            REG_RDATA1: rd_mux = rdata_ext[63:32];
            REG_RDATA2: rd_mux = rdata_ext[95:64];
            default:    rd_mux = '0;
        endcase
    end

    assign start_wr = cpu_wr_strb && (cpu_addr == REG_CTRL) && cpu_din[CTRL_WR];
    assign start_rd = cpu_wr_strb && (cpu_addr == REG_CTRL) && cpu_din[CTRL_RD] && !cpu_din[CTRL_WR];

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_wdata <= '0;
            stage_be    <= '1;
            stage_addr  <= '0;
            rdata_q     <= '0;
            cpu_ack     <= 1'b0;
            cpu_dout    <= '0;
        end else begin
            cpu_ack  <= cpu_wr_strb | cpu_rd_strb;
            cpu_dout <= cpu_rd_strb ? rd_mux : '0;
            if (cpu_wr_strb) begin
                for (int i = 0; i < BURST_W; i++) begin
                    if (cpu_addr == REG_WDATA0 + 4'(i / 32))
                        stage_wdata[i] <= cpu_din[i % 32];
                end
                if (cpu_addr == REG_BE)
                    stage_be <= cpu_din[2*BW_WIDTH-1:0];
                if (cpu_addr == REG_ADDR)
                    stage_addr <= cpu_din[ADDR_WIDTH-1:0];
            end
            if (rd_capture)
                rdata_q <= rd_data;
        end
    end
endmodule

// File: rtl/qdrc_cpu_bridge.sv
// rtl/qdrc_cpu_bridge.sv - register-mapped CPU master driving single QDR burst writes/reads with read timeout
module qdrc_cpu_bridge
    import qdrc_pkg::*;
#(
    parameter int DATA_WIDTH = 36,
    parameter int BW_WIDTH   = 4,
    parameter int ADDR_WIDTH = 21,
    parameter int RD_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         cpu_addr,
    input  logic               cpu_wr_strb,
    input  logic               cpu_rd_strb,
    input  logic [31:0]        cpu_din,
    output logic [31:0]        cpu_dout,
    output logic               cpu_ack,
    qdrc_cpu_bridge_if.master  usr
);
    localparam int CNT_W = $clog2(RD_TIMEOUT);

    qdrc_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    timeout_q, timeout_d;
    logic                    reject_q, reject_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [2*DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [2*BW_WIDTH-1:0]   be_q, be_d;
    logic                    rd_capture;
    logic                    start_wr, start_rd;
    logic [2*DATA_WIDTH-1:0] stage_wdata;
    logic [2*BW_WIDTH-1:0]   stage_be;
    logic [ADDR_WIDTH-1:0]   stage_addr;

    qdrc_cpu_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .BW_WIDTH   (BW_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regfile (
        .clk         (clk),
        .reset       (reset),
        .cpu_addr    (cpu_addr),
        .cpu_wr_strb (cpu_wr_strb),
        .cpu_rd_strb (cpu_rd_strb),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .cpu_ack     (cpu_ack),
        .busy        (state_q != S_IDLE),
        .timeout     (timeout_q),
        .reject      (reject_q),
        .phy_rdy     (usr.phy_rdy),
        .rd_capture  (rd_capture),
        .rd_data     (usr.usr_rd_data),
        .stage_wdata (stage_wdata),
        .stage_be    (stage_be),
        .stage_addr  (stage_addr),
        .start_wr    (start_wr),
        .start_rd    (start_rd)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
        reject_d   = reject_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rd_capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Starts only land here; CTRL writes in any other state fall through untouched.
                if (start_wr || start_rd) begin
                    timeout_d = 1'b0;
                    if (!usr.phy_rdy) begin
                        reject_d = 1'b1;
                    end else begin
                        reject_d = 1'b0;
                        addr_d   = stage_addr;
                        wdata_d  = stage_wdata;
                        be_d     = stage_be;
                        state_d  = start_wr ? S_WRITE : S_READ_REQ;
                    end
                end
            end
            S_WRITE:    state_d = S_IDLE;
            S_READ_REQ: begin
                cnt_d   = '0;
                state_d = S_READ_WAIT;
            end
            S_READ_WAIT: begin
                // Data on the final counted cycle still wins over the timeout.
                if (usr.usr_rd_dvld) begin
                    rd_capture = 1'b1;
                    state_d    = S_IDLE;
                end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            reject_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            reject_q  <= reject_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
        end
    end

    assign usr.usr_wr_strb = (state_q == S_WRITE);
    assign usr.usr_rd_strb = (state_q == S_READ_REQ);
    assign usr.usr_addr    = addr_q;
    assign usr.usr_wr_data = wdata_q;
    assign usr.usr_wr_be   = be_q;
endmodule

// File: tb/tb_qdrc_cpu_bridge.sv
// tb/tb_qdrc_cpu_bridge.sv - randomized self-checking bench for qdrc_cpu_bridge against a register/memory model
module tb_qdrc_cpu_bridge;
    import qdrc_pkg::*;

    localparam int DW = 36;
    localparam int BWW = 4;
    localparam int AW = 21;
    localparam int TO = 8;
    localparam int W = 2 * DW;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cpu_addr = '0;
    logic        cpu_wr_strb = 1'b0;
    logic        cpu_rd_strb = 1'b0;
    logic [31:0] cpu_din = '0;
    logic [31:0] cpu_dout;
    logic        cpu_ack;

    qdrc_cpu_bridge_if #(.DATA_WIDTH(DW), .BW_WIDTH(BWW), .ADDR_WIDTH(AW)) usr ();

    qdrc_cpu_bridge #(
        .DATA_WIDTH (DW),
        .BW_WIDTH   (BWW),
        .ADDR_WIDTH (AW),
        .RD_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_addr    (cpu_addr),
        .cpu_wr_strb (cpu_wr_strb),
        .cpu_rd_strb (cpu_rd_strb),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .cpu_ack     (cpu_ack),
        .usr         (usr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Controller model: memory fed by observed writes, reads answered resp_lat cycles after the strobe (0 = never).
    int wr_cnt = 0, rd_cnt = 0, overlap = 0, resp_lat = 3, cd = 0;
    logic [AW-1:0] last_wr_addr;
    logic [W-1:0]  last_wr_data;
    logic [7:0]    last_wr_be;
    logic [W-1:0]  resp;
    logic [W-1:0]  dut_mem [logic [AW-1:0]];

    function automatic logic [W-1:0] pat(input logic [AW-1:0] a);
        return {30'h15A5A5A5, a, ~a};
    endfunction

    initial begin
        usr.usr_rd_dvld = 1'b0;
        usr.usr_rd_data = '0;
        forever begin
            @(negedge clk);
            usr.usr_rd_dvld = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    usr.usr_rd_dvld = 1'b1;
                    usr.usr_rd_data = resp;
                end
            end
            if (usr.usr_wr_strb && usr.usr_rd_strb) overlap++;
            if (usr.usr_wr_strb) begin
                wr_cnt++;
                last_wr_addr = usr.usr_addr;
                last_wr_data = usr.usr_wr_data;
                last_wr_be   = usr.usr_wr_be;
                dut_mem[usr.usr_addr] = usr.usr_wr_data;
            end
            if (usr.usr_rd_strb) begin
                rd_cnt++;
                if (resp_lat > 0) begin
                    cd = resp_lat;
                    resp = dut_mem.exists(usr.usr_addr) ? dut_mem[usr.usr_addr] : pat(usr.usr_addr);
                end
            end
        end
    end

    // Reference state of the bridge registers and the memory behind it.
    logic [95:0]  m_wd;
    logic [7:0]   m_be;
    logic [AW-1:0] m_addr;
    logic [W-1:0] m_rdata;
    logic         m_timeout;
    logic [W-1:0] ref_mem [logic [AW-1:0]];

    function automatic logic [W-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        cpu_addr = a; cpu_din = d; cpu_wr_strb = 1'b1;
        tick();
        cpu_wr_strb = 1'b0;
        check_eq("wr_ack", cpu_ack, 1);
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
        cpu_addr = a; cpu_rd_strb = 1'b1;
        tick();
        cpu_rd_strb = 1'b0;
        d = cpu_dout;
        check_eq("rd_ack", cpu_ack, 1);
    endtask

    task automatic expect_reg(input string tag, input logic [3:0] a, input logic [31:0] e);
        logic [31:0] v;
        cpu_read(a, v);
        check_eq(tag, v, e);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        int done = 0;
        for (int i = 0; i < 40 && done == 0; i++) begin
            cpu_read(REG_STATUS, s);
            if (!s[ST_BUSY]) done = 1;
        end
        check_eq(tag, done, 1);
    endtask

    task automatic stage_word(input int k, input logic [31:0] d);
        cpu_write(REG_WDATA0 + 4'(k), d);
        m_wd[32*k +: 32] = d;
        m_wd[95:W] = '0;
    endtask

    function automatic logic [31:0] status_exp(input logic busy, input logic tmo, input logic rej);
        return {28'h0, rej, 1'b1, tmo, busy};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int w0, r0, hit, k, op;
        logic [31:0] s, d;
        logic [95:0] rx;
        usr.phy_rdy = 1'b1;
        m_wd = '0; m_be = 8'hFF; m_addr = '0; m_rdata = '0; m_timeout = 1'b0;

        tick(3);
        check_eq("rst_ack", cpu_ack, 0);
        check_eq("rst_dout", cpu_dout, 0);
        check_eq("rst_strobes", {usr.usr_wr_strb, usr.usr_rd_strb}, 0);
        check_eq("rst_usr_addr", usr.usr_addr, 0);
        check_eq("rst_usr_wdata", usr.usr_wr_data, 0);
        check_eq("rst_usr_be", usr.usr_wr_be, 0);
        reset = 1'b0;
        tick();
        expect_reg("rst_be_reg", REG_BE, 32'hFF);
        expect_reg("rst_addr_reg", REG_ADDR, 32'h0);
        expect_reg("rst_status", REG_STATUS, status_exp(0, 0, 0));
        expect_reg("rst_rdata0", REG_RDATA0, 32'h0);

        // Loopback write then read
        stage_word(0, 32'h89ABCDEF);
        stage_word(1, 32'h01234567);
        stage_word(2, 32'h000000A5);
        cpu_write(REG_ADDR, 32'h0001F00A);
        m_addr = 21'h1F00A;
        expect_reg("wdata2_rb", REG_WDATA2, 32'hA5);
        w0 = wr_cnt;
        cpu_write(REG_CTRL, 32'h1);
        check_eq("lb_wr_strb", usr.usr_wr_strb, 1);
        check_eq("lb_wr_data", usr.usr_wr_data, 72'hA50123456789ABCDEF);
        check_eq("lb_wr_addr", usr.usr_addr, 21'h1F00A);
        check_eq("lb_wr_be", usr.usr_wr_be, 8'hFF);
        expect_reg("lb_wr_busy", REG_STATUS, status_exp(1, 0, 0));
        check_eq("lb_wr_strb_end", usr.usr_wr_strb, 0);
        wait_idle("lb_wr_idle");
        check_eq("lb_wr_count", wr_cnt - w0, 1);
        ref_mem[m_addr] = m_wd[W-1:0];

        resp_lat = 3;
        r0 = rd_cnt;
        cpu_write(REG_CTRL, 32'h2);
        check_eq("lb_rd_strb", usr.usr_rd_strb, 1);
        wait_idle("lb_rd_idle");
        check_eq("lb_rd_count", rd_cnt - r0, 1);
        m_rdata = ref_read(m_addr);
        expect_reg("lb_rdata0", REG_RDATA0, 32'h89ABCDEF);
        expect_reg("lb_rdata1", REG_RDATA1, 32'h01234567);
        expect_reg("lb_rdata2", REG_RDATA2, 32'h000000A5);
        expect_reg("lb_status", REG_STATUS, status_exp(0, 0, 0));

        // Reject while the PHY is not calibrated
        usr.phy_rdy = 1'b0;
        w0 = wr_cnt;
        cpu_write(REG_CTRL, 32'h1);
        check_eq("rej_no_strb", usr.usr_wr_strb, 0);
        tick(2);
        expect_reg("rej_status", REG_STATUS, 32'h8);
        check_eq("rej_count", wr_cnt - w0, 0);
        usr.phy_rdy = 1'b1;
        cpu_write(REG_CTRL, 32'h1);
        wait_idle("rej_retry_idle");
        expect_reg("rej_cleared", REG_STATUS, status_exp(0, 0, 0));
        check_eq("rej_retry_count", wr_cnt - w0, 1);

        // CTRL=3 writes only; CTRL writes while busy are dropped
        w0 = wr_cnt; r0 = rd_cnt;
        cpu_write(REG_CTRL, 32'h3);
        wait_idle("both_idle");
        check_eq("both_wr", wr_cnt - w0, 1);
        check_eq("both_rd", rd_cnt - r0, 0);
        w0 = wr_cnt; r0 = rd_cnt;
        resp_lat = 6;
        cpu_write(REG_CTRL, 32'h2);
        cpu_write(REG_CTRL, 32'h1);
        cpu_write(REG_CTRL, 32'h2);
        wait_idle("busy_ign_idle");
        check_eq("busy_ign_wr", wr_cnt - w0, 0);
        check_eq("busy_ign_rd", rd_cnt - r0, 1);

        // Timeout with a late response arriving two cycles after it
        resp_lat = TO + 2;
        cpu_write(REG_CTRL, 32'h2);
        hit = -1;
        for (int i = 0; i < 20; i++) begin
            cpu_read(REG_STATUS, s);
            if (s[ST_TIMEOUT] && hit < 0) hit = i;
        end
        check_eq("to_cycle", hit, TO + 1);
        expect_reg("to_status", REG_STATUS, status_exp(0, 1, 0));
        expect_reg("to_rdata0", REG_RDATA0, 32'h89ABCDEF);
        expect_reg("to_rdata2", REG_RDATA2, 32'h000000A5);

        // Response on the final counted cycle is a success
        stage_word(0, 32'hDEADBEEF);
        stage_word(1, 32'hCAFEF00D);
        stage_word(2, 32'h0000005C);
        cpu_write(REG_ADDR, 32'h00000123);
        m_addr = 21'h123;
        cpu_write(REG_CTRL, 32'h1);
        wait_idle("last_wr_idle");
        ref_mem[m_addr] = m_wd[W-1:0];
        resp_lat = TO;
        cpu_write(REG_CTRL, 32'h2);
        wait_idle("last_rd_idle");
        m_rdata = ref_read(m_addr);
        expect_reg("last_status", REG_STATUS, status_exp(0, 0, 0));
        expect_reg("last_rdata0", REG_RDATA0, 32'hDEADBEEF);
        expect_reg("last_rdata1", REG_RDATA1, 32'hCAFEF00D);
        expect_reg("last_rdata2", REG_RDATA2, 32'h5C);

        // Randomized operations against the model
        for (int it = 0; it < 30; it++) begin
            for (int r = 0; r < 5; r++) begin
                if ($urandom_range(0, 1) == 1) begin
                    d = $urandom;
                    if (r < 3) stage_word(r, d);
                    else if (r == 3) begin cpu_write(REG_BE, d); m_be = d[7:0]; end
                    else begin
                        d = (d & 32'hFFE0_0000) | 32'($urandom_range(0, 7));
                        cpu_write(REG_ADDR, d);
                        m_addr = d[AW-1:0];
                    end
                end
            end
            k = $urandom_range(0, 4);
            rx = (k < 3) ? {64'h0, m_wd[32*k +: 32]} : (k == 3) ? {88'h0, m_be} : {75'h0, m_addr};
            expect_reg("rnd_stage_rb", REG_WDATA0 + 4'(k), rx[31:0]);

            op = $urandom_range(0, 2);
            w0 = wr_cnt; r0 = rd_cnt;
            if (op == 0) begin
                cpu_write(REG_CTRL, ($urandom_range(0, 1) == 1) ? 32'h1 : 32'h3);
            end else begin
                resp_lat = $urandom_range(0, TO + 3);
                cpu_write(REG_CTRL, 32'h2);
            end
            wait_idle("rnd_idle");
            tick(TO + 4);
            if (op == 0) begin
                check_eq("rnd_wr_count", {wr_cnt - w0, rd_cnt - r0}, {32'd1, 32'd0});
                check_eq("rnd_wr_data", last_wr_data, m_wd[W-1:0]);
                check_eq("rnd_wr_addr", last_wr_addr, m_addr);
                check_eq("rnd_wr_be", last_wr_be, m_be);
                ref_mem[m_addr] = m_wd[W-1:0];
                m_timeout = 1'b0;
            end else begin
                check_eq("rnd_rd_count", {wr_cnt - w0, rd_cnt - r0}, {32'd0, 32'd1});
                m_timeout = !(resp_lat >= 1 && resp_lat <= TO);
                if (!m_timeout) m_rdata = ref_read(m_addr);
            end
            expect_reg("rnd_status", REG_STATUS, status_exp(0, m_timeout, 0));
            k = $urandom_range(0, 2);
            rx = {24'h0, m_rdata};
            expect_reg("rnd_rdata", REG_RDATA0 + 4'(k), rx[32*k +: 32]);
        end

        // Reset in the middle of a read
        cpu_write(REG_BE, 32'h5A);
        cpu_write(REG_ADDR, 32'h00000123);
        resp_lat = 5;
        cpu_write(REG_CTRL, 32'h2);
        tick(2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_rst_strobes", {usr.usr_wr_strb, usr.usr_rd_strb}, 0);
        expect_reg("mid_rst_status", REG_STATUS, status_exp(0, 0, 0));
        expect_reg("mid_rst_be", REG_BE, 32'hFF);
        expect_reg("mid_rst_addr", REG_ADDR, 32'h0);
        tick(6);
        expect_reg("mid_rst_rdata0", REG_RDATA0, 32'h0);
        expect_reg("mid_rst_status2", REG_STATUS, status_exp(0, 0, 0));

        check_eq("strobe_overlap", overlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
